// File: rtl/id_queue_pkg.sv
// Shared decode definitions for the id_queue stage: opcodes, funct3 codes,
// the immediate-format enum and the immediate extraction helper.
package id_queue_pkg;

    localparam int          ID_DEPTH_DEF = 4;
    localparam logic [31:0] INST_NOP     = 32'h0000_0001;

    localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
    localparam logic [6:0] INST_TYPE_L   = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S   = 7'b0100011;
    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
    localparam logic [6:0] INST_JAL      = 7'b1101111;
    localparam logic [6:0] INST_JALR     = 7'b1100111;
    localparam logic [6:0] INST_LUI      = 7'b0110111;
    localparam logic [6:0] INST_AUIPC    = 7'b0010111;
    localparam logic [6:0] INST_CSR      = 7'b1110011;
    localparam logic [6:0] INST_NOP_OP   = 7'b0000001;
    localparam logic [6:0] INST_FENCE    = 7'b0001111;
    localparam logic [6:0] INST_TYPE_N   = 7'b0001011;

    localparam logic [2:0] INST_LB  = 3'b000, INST_LH  = 3'b001, INST_LW   = 3'b010;
    localparam logic [2:0] INST_LBU = 3'b100, INST_LHU = 3'b101;
    localparam logic [2:0] INST_SB  = 3'b000, INST_SH  = 3'b001, INST_SW   = 3'b010;
    localparam logic [2:0] INST_BEQ = 3'b000, INST_BNE = 3'b001, INST_BLT  = 3'b100;
    localparam logic [2:0] INST_BGE = 3'b101, INST_BLTU = 3'b110, INST_BGEU = 3'b111;
    localparam logic [2:0] INST_CSRRW  = 3'b001, INST_CSRRS  = 3'b010, INST_CSRRC  = 3'b011;
    localparam logic [2:0] INST_CSRRWI = 3'b101, INST_CSRRSI = 3'b110, INST_CSRRCI = 3'b111;
    localparam logic [2:0] INST_SID = 3'b000, INST_RT = 3'b001, INST_IF = 3'b010;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] r_imm;
        case (fmt)
            IMM_I:   r_imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   r_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   r_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   r_imm = {inst[31:12], 12'b0};
            IMM_J:   r_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: r_imm = 32'b0;
        endcase
        return r_imm;
    endfunction

endpackage

// File: rtl/id_queue_dec.sv
// Pure combinational decode of one instruction word into the decode bundle.
// Optional M-extension decode is enabled with macro ID_QUEUE_RVM_EN.
module id_queue_dec
    import id_queue_pkg::*;
#(
    parameter int NREG_RT = 31
)(
    input  logic [31:0] i_inst,
    output logic [4:0]  o_reg1_raddr,
    output logic [4:0]  o_reg2_raddr,
    output logic        o_reg_we,
    output logic [4:0]  o_reg_waddr,
    output logic [31:0] o_imm,
    output logic        o_csr_we,
    output logic [11:0] o_csr_addr,
    output logic        o_illegal
);
    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    imm_fmt_e   w_fmt;

    assign w_opcode = i_inst[6:0];
    assign w_rd     = i_inst[11:7];
    assign w_funct3 = i_inst[14:12];
    assign w_rs1    = i_inst[19:15];
    assign w_rs2    = i_inst[24:20];
    assign w_funct7 = i_inst[31:25];

    always_comb begin
        o_reg1_raddr = 5'd0;
        o_reg2_raddr = 5'd0;
        o_reg_we     = 1'b0;
        o_reg_waddr  = 5'd0;
        o_csr_we     = 1'b0;
        o_csr_addr   = 12'd0;
        o_illegal    = 1'b0;
        w_fmt        = IMM_NONE;
        case (w_opcode)
            INST_TYPE_I: begin
                o_reg1_raddr = w_rs1;
                o_reg_we     = 1'b1;
                o_reg_waddr  = w_rd;
                w_fmt        = IMM_I;
            end
            INST_TYPE_L: begin
                case (w_funct3)
                    INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU: begin
                        o_reg1_raddr = w_rs1;
                        o_reg_we     = 1'b1;
                        o_reg_waddr  = w_rd;
                        w_fmt        = IMM_I;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            INST_TYPE_R_M: begin
                if (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000) begin
                    o_reg1_raddr = w_rs1;
                    o_reg2_raddr = w_rs2;
                    o_reg_we     = 1'b1;
                    o_reg_waddr  = w_rd;
                end
`ifdef ID_QUEUE_RVM_EN
                // Divide group writes back later from the divider, so no we here
                else if (w_funct7 == 7'b0000001) begin
                    o_reg1_raddr = w_rs1;
                    o_reg2_raddr = w_rs2;
                    o_reg_we     = !w_funct3[2];
                    o_reg_waddr  = w_rd;
                end
`endif
                else begin
                    o_illegal = 1'b1;
                end
            end
            INST_TYPE_S: begin
                case (w_funct3)
                    INST_SB, INST_SH, INST_SW: begin
                        o_reg1_raddr = w_rs1;
                        o_reg2_raddr = w_rs2;
                        w_fmt        = IMM_S;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            INST_TYPE_B: begin
                case (w_funct3)
                    INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU: begin
                        o_reg1_raddr = w_rs1;
                        o_reg2_raddr = w_rs2;
                        w_fmt        = IMM_B;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            INST_JAL: begin
                o_reg_we    = 1'b1;
                o_reg_waddr = w_rd;
                w_fmt       = IMM_J;
            end
            INST_JALR: begin
                if (w_funct3 == 3'b000) begin
                    o_reg1_raddr = w_rs1;
                    o_reg_we     = 1'b1;
                    o_reg_waddr  = w_rd;
                    w_fmt        = IMM_I;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            INST_LUI, INST_AUIPC: begin
                o_reg_we    = 1'b1;
                o_reg_waddr = w_rd;
                w_fmt       = IMM_U;
            end
            INST_CSR: begin
                case (w_funct3)
                    INST_CSRRW, INST_CSRRS, INST_CSRRC,
                    INST_CSRRWI, INST_CSRRSI, INST_CSRRCI: begin
                        // funct3[2] marks the zimm forms, whose rs1 field is data
                        o_reg1_raddr = w_funct3[2] ? 5'd0 : w_rs1;
                        o_reg_we     = 1'b1;
                        o_reg_waddr  = w_rd;
                        o_csr_we     = 1'b1;
                        o_csr_addr   = i_inst[31:20];
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            INST_TYPE_N: begin
                case (w_funct3)
                    INST_SID: o_reg_we = 1'b0;
                    INST_RT: begin
                        o_reg_we    = 1'b1;
                        o_reg_waddr = w_rd;
                    end
                    INST_IF: begin
                        o_reg1_raddr = w_rs1;
                        o_reg2_raddr = 5'(NREG_RT);
                        o_reg_we     = 1'b1;
                        o_reg_waddr  = w_rd;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            INST_NOP_OP, INST_FENCE: o_illegal = 1'b0;
            default: o_illegal = 1'b1;
        endcase
    end

    assign o_imm = imm_gen(i_inst, w_fmt);

endmodule

// File: rtl/id_queue.sv
// Buffered decode stage: circular instruction FIFO feeding a registered decode
// bundle, flushed on ex jumps. Optional feature macro: ID_QUEUE_RVM_EN.
module id_queue
    import id_queue_pkg::*;
#(
    parameter int DEPTH   = ID_DEPTH_DEF,
    parameter int ADDR_W  = 32,
    parameter int NREG_RT = 31
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           inst_i,
    input  logic [ADDR_W-1:0]     inst_addr_i,
    input  logic                  ex_jump_flag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           inst_o,
    output logic [ADDR_W-1:0]     inst_addr_o,
    output logic [4:0]            reg1_raddr_o,
    output logic [4:0]            reg2_raddr_o,
    output logic                  reg_we_o,
    output logic [4:0]            reg_waddr_o,
    output logic [31:0]           imm_o,
    output logic                  csr_we_o,
    output logic [11:0]           csr_addr_o,
    output logic                  illegal_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]       r_mem_inst [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_in_ready;
    logic              r_out_valid;

    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_inst_addr;
    logic [4:0]        r_reg1_raddr;
    logic [4:0]        r_reg2_raddr;
    logic              r_reg_we;
    logic [4:0]        r_reg_waddr;
    logic [31:0]       r_imm;
    logic              r_csr_we;
    logic [11:0]       r_csr_addr;
    logic              r_illegal;

    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_head_inst;
    logic [4:0]        w_reg1_raddr;
    logic [4:0]        w_reg2_raddr;
    logic              w_reg_we;
    logic [4:0]        w_reg_waddr;
    logic [31:0]       w_imm;
    logic              w_csr_we;
    logic [11:0]       w_csr_addr;
    logic              w_illegal;

    // Reset and ex jump share one clear path; it wins over push and pop
    assign w_flush     = !rst || ex_jump_flag_i;
    assign w_push      = in_valid_i && r_in_ready;
    assign w_pop       = (r_count != '0) && (!r_out_valid || out_ready_i);
    assign w_head_inst = r_mem_inst[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_mem_inst[r_wr_ptr] <= inst_i;
            r_mem_addr[r_wr_ptr] <= inst_addr_i;
        end
    end

    // in_ready is a registered !full so it never depends on out_ready_i
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != CNT_W'(DEPTH));
        end
    end

    id_queue_dec #(
        .NREG_RT (NREG_RT)
    ) u_dec (
        .i_inst       (w_head_inst),
        .o_reg1_raddr (w_reg1_raddr),
        .o_reg2_raddr (w_reg2_raddr),
        .o_reg_we     (w_reg_we),
        .o_reg_waddr  (w_reg_waddr),
        .o_imm        (w_imm),
        .o_csr_we     (w_csr_we),
        .o_csr_addr   (w_csr_addr),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_out_valid  <= 1'b0;
            r_inst       <= INST_NOP;
            r_inst_addr  <= '0;
            r_reg1_raddr <= 5'd0;
            r_reg2_raddr <= 5'd0;
            r_reg_we     <= 1'b0;
            r_reg_waddr  <= 5'd0;
            r_imm        <= 32'd0;
            r_csr_we     <= 1'b0;
            r_csr_addr   <= 12'd0;
            r_illegal    <= 1'b0;
        end else if (w_pop) begin
            r_out_valid  <= 1'b1;
            r_inst       <= w_head_inst;
            r_inst_addr  <= r_mem_addr[r_rd_ptr];
            r_reg1_raddr <= w_reg1_raddr;
            r_reg2_raddr <= w_reg2_raddr;
            r_reg_we     <= w_reg_we;
            r_reg_waddr  <= w_reg_waddr;
            r_imm        <= w_imm;
            r_csr_we     <= w_csr_we;
            r_csr_addr   <= w_csr_addr;
            r_illegal    <= w_illegal;
        end else if (r_out_valid && out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready_o   = r_in_ready;
    assign out_valid_o  = r_out_valid;
    assign count_o      = r_count;
    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign reg1_raddr_o = r_reg1_raddr;
    assign reg2_raddr_o = r_reg2_raddr;
    assign reg_we_o     = r_reg_we;
    assign reg_waddr_o  = r_reg_waddr;
    assign imm_o        = r_imm;
    assign csr_we_o     = r_csr_we;
    assign csr_addr_o   = r_csr_addr;
    assign illegal_o    = r_illegal;

endmodule

// File: tb/tb_id_queue.sv
// Self-checking bench for id_queue: a queue-level model plus instruction-level
// decode expectations, compared every cycle, with literal spot checks.
module tb_id_queue;

    localparam int DEPTH = 4;
`ifdef ID_QUEUE_RVM_EN
    localparam bit RVM = 1'b1;
`else
    localparam bit RVM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        ex_jump_flag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [4:0]  reg1_raddr_o;
    logic [4:0]  reg2_raddr_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] imm_o;
    logic        csr_we_o;
    logic [11:0] csr_addr_o;
    logic        illegal_o;
    logic [2:0]  count_o;

    always #5 clk = ~clk;

    id_queue #(.DEPTH(DEPTH), .ADDR_W(32), .NREG_RT(31)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .ex_jump_flag_i(ex_jump_flag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .inst_o(inst_o),
        .inst_addr_o(inst_addr_o), .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .imm_o(imm_o), .csr_we_o(csr_we_o),
        .csr_addr_o(csr_addr_o), .illegal_o(illegal_o), .count_o(count_o)
    );

    typedef struct packed {
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] imm;
        logic        csr_we;
        logic [11:0] csr;
        logic        ill;
    } dec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } ent_t;

    ent_t        q[$];
    ent_t        m_bun;
    bit          m_valid;
    bit          m_ready;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_xfer = 0;
    logic [31:0] pc = 32'h0000_1000;

    // Expected decode, written per instruction class straight from the ISA fields
    function automatic dec_t exp_dec(input logic [31:0] w);
        dec_t d;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
        d = '0;
        rd = w[11:7]; rs1 = w[19:15]; rs2 = w[24:20]; f3 = w[14:12]; f7 = w[31:25];
        imm_i = 32'($signed(w[31:20]));
        imm_s = 32'($signed({w[31:25], w[11:7]}));
        imm_b = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        imm_j = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        imm_u = {w[31:12], 12'h000};
        case (w[6:0])
            7'h13: begin d.r1 = rs1; d.we = 1; d.wa = rd; d.imm = imm_i; end
            7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                       d.r1 = rs1; d.we = 1; d.wa = rd; d.imm = imm_i;
                   end else d.ill = 1;
            7'h33: if (f7 == 7'h00 || f7 == 7'h20) begin
                       d.r1 = rs1; d.r2 = rs2; d.we = 1; d.wa = rd;
                   end else if (f7 == 7'h01 && RVM) begin
                       d.r1 = rs1; d.r2 = rs2; d.wa = rd; d.we = (f3 < 3'd4);
                   end else d.ill = 1;
            7'h23: if (f3 <= 3'd2) begin d.r1 = rs1; d.r2 = rs2; d.imm = imm_s; end
                   else d.ill = 1;
            7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin d.r1 = rs1; d.r2 = rs2; d.imm = imm_b; end
                   else d.ill = 1;
            7'h6F: begin d.we = 1; d.wa = rd; d.imm = imm_j; end
            7'h67: if (f3 == 3'd0) begin d.r1 = rs1; d.we = 1; d.wa = rd; d.imm = imm_i; end
                   else d.ill = 1;
            7'h37, 7'h17: begin d.we = 1; d.wa = rd; d.imm = imm_u; end
            7'h73: if (f3 == 3'd0 || f3 == 3'd4) d.ill = 1;
                   else begin
                       d.r1 = (f3 >= 3'd5) ? 5'd0 : rs1;
                       d.we = 1; d.wa = rd; d.csr_we = 1; d.csr = w[31:20];
                   end
            7'h0B: case (f3)
                       3'd0: d = '0;
                       3'd1: begin d.we = 1; d.wa = rd; end
                       3'd2: begin d.r1 = rs1; d.r2 = 5'd31; d.we = 1; d.wa = rd; end
                       default: d.ill = 1;
                   endcase
            7'h01, 7'h0F: d = '0;
            default: d.ill = 1;
        endcase
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Queue-level model: applies the handshake rules to the inputs seen at an edge
    task automatic model_step();
        bit push, pop;
        if (!rst || ex_jump_flag_i) begin
            q.delete();
            m_valid = 1'b0;
            m_ready = 1'b1;
            return;
        end
        push = in_valid_i && m_ready;
        pop  = (q.size() > 0) && (!m_valid || out_ready_i);
        if (m_valid && out_ready_i) begin
            n_xfer++;
            $display("xfer %0d: addr=%08h inst=%08h", n_xfer, m_bun.addr, m_bun.inst);
        end
        if (pop) begin
            m_bun   = q.pop_front();
            m_valid = 1'b1;
        end else if (m_valid && out_ready_i) begin
            m_valid = 1'b0;
        end
        if (push) q.push_back({inst_i, inst_addr_i});
        m_ready = (q.size() != DEPTH);
    endtask

    task automatic compare_model();
        dec_t e;
        chk("out_valid", 32'(out_valid_o), 32'(m_valid));
        chk("in_ready", 32'(in_ready_o), 32'(m_ready));
        chk("count", 32'(count_o), 32'(q.size()));
        if (m_valid) begin
            e = exp_dec(m_bun.inst);
            chk("inst", inst_o, m_bun.inst);
            chk("inst_addr", inst_addr_o, m_bun.addr);
            chk("reg1_raddr", 32'(reg1_raddr_o), 32'(e.r1));
            chk("reg2_raddr", 32'(reg2_raddr_o), 32'(e.r2));
            chk("reg_we", 32'(reg_we_o), 32'(e.we));
            chk("reg_waddr", 32'(reg_waddr_o), 32'(e.wa));
            chk("imm", imm_o, e.imm);
            chk("csr_we", 32'(csr_we_o), 32'(e.csr_we));
            chk("csr_addr", 32'(csr_addr_o), 32'(e.csr));
            chk("illegal", 32'(illegal_o), 32'(e.ill));
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] w, input bit rdy,
                         input bit jmp = 1'b0, input bit rn = 1'b1);
        in_valid_i     = v;
        inst_i         = w;
        inst_addr_i    = pc;
        out_ready_i    = rdy;
        ex_jump_flag_i = jmp;
        rst            = rn;
        @(posedge clk);
        model_step();
        if (v) pc = pc + 32'd4;
        #1;
        if (chk_en) compare_model();
    endtask

    logic [31:0] stream [16] = '{
        32'h123452B7, 32'h0020A423, 32'h010000EF, 32'h300211F3,
        32'h3052E073, 32'h0004A38B, 32'h0000120B, 32'h0001800B,
        32'h0000500B, 32'hFF812303, 32'h00013303, 32'h402081B3,
        32'h202081B3, 32'h0FF0000F, 32'h00000001, 32'h0000007F
    };
    logic [31:0] fill5 [5] = '{32'h004280E7, 32'h00001517, 32'h00002063,
                               32'h02209033, 32'h0220C033};
    dec_t pin;

    initial begin
        cycle(0, 32'h0, 0, 0, 0);
        chk_en = 1'b1;
        cycle(0, 32'h0, 0, 0, 0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_inst_nop", inst_o, 32'h0000_0001);

        // Model pins against hand-decoded words
        pin = exp_dec(32'hFE000EE3);
        chk("model_beq_imm", pin.imm, 32'hFFFFFFFC);
        pin = exp_dec(32'hFF812303);
        chk("model_lw_imm", pin.imm, 32'hFFFFFFF8);
        pin = exp_dec(32'h010000EF);
        chk("model_jal_imm", pin.imm, 32'h00000010);

        // addi x1,x0,5: visible two edges after the push
        cycle(1, 32'h00500093, 0);
        cycle(0, 32'h0, 0);
        chk("addi_valid", 32'(out_valid_o), 32'd1);
        chk("addi_waddr", 32'(reg_waddr_o), 32'd1);
        chk("addi_we", 32'(reg_we_o), 32'd1);
        chk("addi_imm", imm_o, 32'd5);
        chk("addi_illegal", 32'(illegal_o), 32'd0);
        cycle(0, 32'h0, 1);

        // Five pushes against a stalled ex fill queue plus bundle
        for (int i = 0; i < 5; i++) cycle(1, fill5[i], 0);
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_in_ready", 32'(in_ready_o), 32'd0);
        cycle(1, 32'h00000013, 0);
        for (int i = 0; i < 7; i++) cycle(0, 32'h0, 1);

        // Flush with three queued while a new word is offered
        for (int i = 0; i < 4; i++) cycle(1, stream[i], 0);
        cycle(1, 32'h00500093, 0, 1);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(out_valid_o), 32'd0);
        cycle(0, 32'h0, 1);
        chk("flush_dropped", 32'(count_o), 32'd0);

        // beq x0,x0,-4
        cycle(1, 32'hFE000EE3, 0);
        cycle(0, 32'h0, 0);
        chk("beq_imm", imm_o, 32'hFFFFFFFC);
        chk("beq_r1", 32'(reg1_raddr_o), 32'd0);
        chk("beq_r2", 32'(reg2_raddr_o), 32'd0);
        chk("beq_we", 32'(reg_we_o), 32'd0);
        cycle(0, 32'h0, 1);

        // mul x0,x1,x2
        cycle(1, 32'h02208033, 0);
        cycle(0, 32'h0, 0);
        chk("mul_we", 32'(reg_we_o), RVM ? 32'd1 : 32'd0);
        chk("mul_illegal", 32'(illegal_o), RVM ? 32'd0 : 32'd1);
        cycle(0, 32'h0, 1);

        // Mixed stream with intermittent ex stalls
        for (int i = 0; i < 16; i++) cycle(1, stream[i], (i % 3) != 0);
        for (int i = 0; i < 10; i++) cycle(0, 32'h0, (i % 2) == 0);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1);

        // Reset while full
        for (int i = 0; i < 5; i++) cycle(1, stream[i + 8], 0);
        chk("pre_rst_count", 32'(count_o), 32'd4);
        cycle(1, 32'h00500093, 0, 0, 0);
        chk("rst_mid_count", 32'(count_o), 32'd0);
        chk("rst_mid_valid", 32'(out_valid_o), 32'd0);
        chk("rst_mid_ready", 32'(in_ready_o), 32'd1);
        cycle(0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
